// File: rtl/id_ex_pipe_ctrl.sv
// id_ex_pipe_ctrl: ID/EX pipeline register with valid bit, stall, flush, load-use bubble insertion and halt latch
// Ports:
//   clk, rst (async, active-high)
//   *_id           decoded instruction fields and controls from the decode stage
//   *_ex           registered fields and controls presented to the execute stage
//   stall_in       execute side cannot accept; flush_in squashes the instruction entering EX
//   valid_ex       EX holds a real instruction; stall_up tells IF/ID to hold (combinational)
//   halted         a HALT has reached EX; issue is frozen until reset
// Optional: define ID_EX_FWD_EN to add wb_regWrite/wb_op0/wb_data write-back bypass onto S1/S2.
module id_ex_pipe_ctrl #(
    parameter int pc_width    = 10,
    parameter int func_width  = 6,
    parameter int const_width = 8,
    parameter int index_width = 3,
    parameter int reg_width   = 32,
    parameter int load_lat    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_id,
    input  logic [pc_width-1:0]    pc_curr_id,
    input  logic [func_width-1:0]  func_id,
    input  logic [const_width-1:0] const_id,
    input  logic                   memRead_id,
    input  logic                   memWrite_id,
    input  logic                   aluToReg_id,
    input  logic                   constToReg_id,
    input  logic                   aluEn_id,
    input  logic                   halt_id,
    input  logic                   regWrite_id,
    input  logic [index_width-1:0] op0_id,
    input  logic [index_width-1:0] op1_id,
    input  logic [index_width-1:0] op2_id,
    input  logic                   use_s1_id,
    input  logic                   use_s2_id,
    input  logic [reg_width-1:0]   S1_id,
    input  logic [reg_width-1:0]   S2_id,
    input  logic                   stall_in,
    input  logic                   flush_in,
`ifdef ID_EX_FWD_EN
    input  logic                   wb_regWrite,
    input  logic [index_width-1:0] wb_op0,
    input  logic [reg_width-1:0]   wb_data,
`endif
    output logic [pc_width-1:0]    pc_curr_ex,
    output logic [func_width-1:0]  func_ex,
    output logic [const_width-1:0] const_ex,
    output logic                   memRead_ex,
    output logic                   memWrite_ex,
    output logic                   aluToReg_ex,
    output logic                   constToReg_ex,
    output logic                   aluEn_ex,
    output logic                   halt_ex,
    output logic                   regWrite_ex,
    output logic [index_width-1:0] op0_ex,
    output logic [reg_width-1:0]   S1_ex,
    output logic [reg_width-1:0]   S2_ex,
    output logic                   valid_ex,
    output logic                   stall_up,
    output logic                   halted
);
    typedef enum logic [1:0] {RUN, BUBBLE, HALTED} state_t;
    state_t                 r_state;
    logic [2:0]             r_cnt;
    logic                   r_valid;
    // control bits: {memRead, memWrite, aluToReg, constToReg, aluEn, halt, regWrite}
    logic [6:0]             r_ctrl;
    logic [pc_width-1:0]    r_pc;
    logic [func_width-1:0]  r_func;
    logic [const_width-1:0] r_const;
    logic [index_width-1:0] r_op0;
    logic [reg_width-1:0]   r_s1;
    logic [reg_width-1:0]   r_s2;
    logic [6:0]             w_ctrl_id;
    logic [reg_width-1:0]   w_s1;
    logic [reg_width-1:0]   w_s2;
    logic                   w_hazard;
    logic                   w_halt_go;

    assign w_ctrl_id = {memRead_id, memWrite_id, aluToReg_id, constToReg_id, aluEn_id, halt_id, regWrite_id};
`ifdef ID_EX_FWD_EN
    assign w_s1 = (wb_regWrite && wb_op0 == op1_id) ? wb_data : S1_id;
    assign w_s2 = (wb_regWrite && wb_op0 == op2_id) ? wb_data : S2_id;
`else
    assign w_s1 = S1_id;
    assign w_s2 = S2_id;
`endif
    assign w_hazard = (r_state == RUN) && r_valid && r_ctrl[6] && r_ctrl[0] && valid_id &&
                      ((use_s1_id && op1_id == r_op0) || (use_s2_id && op2_id == r_op0));
    // a valid HALT sitting in EX moves the block into the halt latch on the following edge
    assign w_halt_go = (r_state == RUN) && r_valid && r_ctrl[1];
    assign stall_up  = stall_in || w_hazard || (r_state == BUBBLE) || (r_state == HALTED);
    assign halted    = (r_state == HALTED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_pc    <= '0;
            r_func  <= '0;
            r_const <= '0;
            r_op0   <= '0;
            r_s1    <= '0;
            r_s2    <= '0;
        end else if (flush_in) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_cnt   <= '0;
            if (r_state == BUBBLE) r_state <= RUN;
        end else if (!stall_in) begin
            if (r_state == HALTED) begin
                r_valid <= 1'b0;
                r_ctrl  <= '0;
            end else if (w_halt_go) begin
                r_valid <= 1'b0;
                r_ctrl  <= '0;
                r_state <= HALTED;
            end else if (w_hazard) begin
                r_valid <= 1'b0;
                r_ctrl  <= '0;
                if (load_lat > 1) begin
                    r_cnt   <= 3'(load_lat - 1);
                    r_state <= BUBBLE;
                end
            end else if (r_state == BUBBLE) begin
                r_valid <= 1'b0;
                r_ctrl  <= '0;
                r_cnt   <= r_cnt - 3'd1;
                if (r_cnt == 3'd1) r_state <= RUN;
            end else begin
                r_valid <= valid_id;
                r_ctrl  <= valid_id ? w_ctrl_id : '0;
                r_pc    <= pc_curr_id;
                r_func  <= func_id;
                r_const <= const_id;
                r_op0   <= op0_id;
                r_s1    <= w_s1;
                r_s2    <= w_s2;
            end
        end
    end

    assign valid_ex      = r_valid;
    assign memRead_ex    = r_ctrl[6];
    assign memWrite_ex   = r_ctrl[5];
    assign aluToReg_ex   = r_ctrl[4];
    assign constToReg_ex = r_ctrl[3];
    assign aluEn_ex      = r_ctrl[2];
    assign halt_ex       = r_ctrl[1];
    assign regWrite_ex   = r_ctrl[0];
    assign pc_curr_ex    = r_pc;
    assign func_ex       = r_func;
    assign const_ex      = r_const;
    assign op0_ex        = r_op0;
    assign S1_ex         = r_s1;
    assign S2_ex         = r_s2;
endmodule

// File: tb/tb_id_ex_pipe_ctrl.sv
// tb_id_ex_pipe_ctrl: directed self-checking bench for id_ex_pipe_ctrl (load_lat=1 and load_lat=3 instances)
module tb_id_ex_pipe_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic valid_id = 1'b0;
    logic [9:0] pc_id = '0;
    logic [5:0] func_id = '0;
    logic [7:0] const_id = '0;
    logic [6:0] ctrl_id = '0;
    logic [2:0] op0_id = '0, op1_id = '0, op2_id = '0;
    logic use_s1 = 1'b0, use_s2 = 1'b0;
    logic [31:0] s1_id = '0, s2_id = '0;
    logic stall_in = 1'b0, flush_in = 1'b0;
`ifdef ID_EX_FWD_EN
    logic wb_regWrite = 1'b0;
    logic [2:0] wb_op0 = '0;
    logic [31:0] wb_data = '0;
`endif
    logic [9:0] pc_a, pc_b;
    logic [5:0] func_a, func_b;
    logic [7:0] const_a, const_b;
    logic [6:0] ctrl_a, ctrl_b;
    logic [2:0] op0_a, op0_b;
    logic [31:0] s1_a, s1_b, s2_a, s2_b;
    logic valid_a, valid_b, stall_a, stall_b, halted_a, halted_b;
    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    id_ex_pipe_ctrl #(.load_lat(1)) u_a (
        .clk(clk), .rst(rst), .valid_id(valid_id), .pc_curr_id(pc_id), .func_id(func_id), .const_id(const_id),
        .memRead_id(ctrl_id[6]), .memWrite_id(ctrl_id[5]), .aluToReg_id(ctrl_id[4]), .constToReg_id(ctrl_id[3]),
        .aluEn_id(ctrl_id[2]), .halt_id(ctrl_id[1]), .regWrite_id(ctrl_id[0]),
        .op0_id(op0_id), .op1_id(op1_id), .op2_id(op2_id), .use_s1_id(use_s1), .use_s2_id(use_s2),
        .S1_id(s1_id), .S2_id(s2_id), .stall_in(stall_in), .flush_in(flush_in),
`ifdef ID_EX_FWD_EN
        .wb_regWrite(wb_regWrite), .wb_op0(wb_op0), .wb_data(wb_data),
`endif
        .pc_curr_ex(pc_a), .func_ex(func_a), .const_ex(const_a),
        .memRead_ex(ctrl_a[6]), .memWrite_ex(ctrl_a[5]), .aluToReg_ex(ctrl_a[4]), .constToReg_ex(ctrl_a[3]),
        .aluEn_ex(ctrl_a[2]), .halt_ex(ctrl_a[1]), .regWrite_ex(ctrl_a[0]),
        .op0_ex(op0_a), .S1_ex(s1_a), .S2_ex(s2_a), .valid_ex(valid_a), .stall_up(stall_a), .halted(halted_a)
    );

    id_ex_pipe_ctrl #(.load_lat(3)) u_b (
        .clk(clk), .rst(rst), .valid_id(valid_id), .pc_curr_id(pc_id), .func_id(func_id), .const_id(const_id),
        .memRead_id(ctrl_id[6]), .memWrite_id(ctrl_id[5]), .aluToReg_id(ctrl_id[4]), .constToReg_id(ctrl_id[3]),
        .aluEn_id(ctrl_id[2]), .halt_id(ctrl_id[1]), .regWrite_id(ctrl_id[0]),
        .op0_id(op0_id), .op1_id(op1_id), .op2_id(op2_id), .use_s1_id(use_s1), .use_s2_id(use_s2),
        .S1_id(s1_id), .S2_id(s2_id), .stall_in(stall_in), .flush_in(flush_in),
`ifdef ID_EX_FWD_EN
        .wb_regWrite(wb_regWrite), .wb_op0(wb_op0), .wb_data(wb_data),
`endif
        .pc_curr_ex(pc_b), .func_ex(func_b), .const_ex(const_b),
        .memRead_ex(ctrl_b[6]), .memWrite_ex(ctrl_b[5]), .aluToReg_ex(ctrl_b[4]), .constToReg_ex(ctrl_b[3]),
        .aluEn_ex(ctrl_b[2]), .halt_ex(ctrl_b[1]), .regWrite_ex(ctrl_b[0]),
        .op0_ex(op0_b), .S1_ex(s1_b), .S2_ex(s2_b), .valid_ex(valid_b), .stall_up(stall_b), .halted(halted_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [9:0] pc, input logic [6:0] c, input logic [2:0] d,
                          input logic [2:0] a, input logic [2:0] b, input logic ua, input logic ub,
                          input logic [31:0] x, input logic [31:0] y);
        valid_id = v; pc_id = pc; ctrl_id = c; op0_id = d; op1_id = a; op2_id = b;
        use_s1 = ua; use_s2 = ub; s1_id = x; s2_id = y;
        #1;
    endtask

    task automatic do_reset();
        stall_in = 0; flush_in = 0;
        set_id(0, 10'h0, 7'h0, 3'd0, 3'd0, 3'd0, 0, 0, 32'h0, 32'h0);
        rst = 1; #2; rst = 0;
        tick();
    endtask

    task automatic test_reset();
        set_id(0, 10'h0, 7'h0, 3'd0, 3'd0, 3'd0, 0, 0, 32'h0, 32'h0);
        tick(); tick();
        n_cmp++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0h want 0", valid_a); end
        n_cmp++; if (ctrl_a !== 7'h0) begin n_fail++; $display("FAIL reset_ctrl got %0h want 0", ctrl_a); end
        n_cmp++; if (halted_a !== 1'b0 || stall_a !== 1'b0) begin n_fail++; $display("FAIL reset_halt_stall got %0h/%0h want 0/0", halted_a, stall_a); end
        rst = 0;
        set_id(1, 10'h033, 7'b0000101, 3'd1, 3'd0, 3'd0, 0, 0, 32'h11, 32'h22);
        tick();
        n_cmp++; if (valid_a !== 1'b1 || pc_a !== 10'h033) begin n_fail++; $display("FAIL pre_rst_capture got %0h/%0h want 1/033", valid_a, pc_a); end
        rst = 1; #1;
        n_cmp++; if (valid_a !== 1'b0 || pc_a !== 10'h0 || ctrl_a !== 7'h0 || s1_a !== 32'h0) begin
            n_fail++; $display("FAIL async_rst got v=%0h pc=%0h c=%0h s1=%0h want all 0", valid_a, pc_a, ctrl_a, s1_a); end
        rst = 0;
        set_id(1, 10'h05A, 7'b0000101, 3'd1, 3'd0, 3'd0, 0, 0, 32'h11, 32'h22);
        tick();
        n_cmp++; if (pc_a !== 10'h05A || valid_a !== 1'b1) begin n_fail++; $display("FAIL post_rst_capture got %0h/%0h want 05A/1", pc_a, valid_a); end
    endtask

    task automatic test_capture();
        do_reset();
        func_id = 6'h2A; const_id = 8'h7F;
        set_id(1, 10'h123, 7'b0111001, 3'd5, 3'd1, 3'd2, 1, 1, 32'hCAFE0001, 32'hBEEF0002);
        tick();
        n_cmp++; if ({func_a, const_a, ctrl_a, op0_a} !== {6'h2A, 8'h7F, 7'b0111001, 3'd5}) begin
            n_fail++; $display("FAIL capture_fields got %0h/%0h/%0h/%0h want 2a/7f/39/5", func_a, const_a, ctrl_a, op0_a); end
        n_cmp++; if (s1_a !== 32'hCAFE0001 || s2_a !== 32'hBEEF0002) begin n_fail++; $display("FAIL capture_ops got %0h/%0h want cafe0001/beef0002", s1_a, s2_a); end
        set_id(0, 10'h124, 7'b1111101, 3'd6, 3'd1, 3'd2, 1, 1, 32'h0, 32'h0);
        tick();
        n_cmp++; if (valid_a !== 1'b0 || ctrl_a !== 7'h0 || pc_a !== 10'h124) begin
            n_fail++; $display("FAIL invalid_id got v=%0h c=%0h pc=%0h want 0/0/124", valid_a, ctrl_a, pc_a); end
    endtask

    task automatic test_load_use_lat1();
        do_reset();
        set_id(1, 10'h100, 7'b1000001, 3'd3, 3'd0, 3'd0, 0, 0, 32'h0, 32'h0);
        tick();
        set_id(1, 10'h101, 7'b0000100, 3'd4, 3'd3, 3'd1, 1, 0, 32'h0, 32'h0);
        n_cmp++; if (stall_a !== 1'b1) begin n_fail++; $display("FAIL lat1_stall got %0h want 1", stall_a); end
        tick();
        n_cmp++; if (valid_a !== 1'b0 || ctrl_a !== 7'h0 || pc_a !== 10'h100) begin
            n_fail++; $display("FAIL lat1_bubble got v=%0h c=%0h pc=%0h want 0/0/100", valid_a, ctrl_a, pc_a); end
        n_cmp++; if (stall_a !== 1'b0) begin n_fail++; $display("FAIL lat1_release got %0h want 0", stall_a); end
        tick();
        n_cmp++; if (valid_a !== 1'b1 || pc_a !== 10'h101) begin n_fail++; $display("FAIL lat1_dep got %0h/%0h want 1/101", valid_a, pc_a); end
    endtask

    task automatic test_load_use_lat3();
        do_reset();
        set_id(1, 10'h100, 7'b1000001, 3'd3, 3'd0, 3'd0, 0, 0, 32'h0, 32'h0);
        tick();
        set_id(1, 10'h101, 7'b0000100, 3'd4, 3'd3, 3'd1, 1, 0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (stall_b !== 1'b1) begin n_fail++; $display("FAIL lat3_stall%0d got %0h want 1", i, stall_b); end
            tick();
            n_cmp++; if (valid_b !== 1'b0) begin n_fail++; $display("FAIL lat3_bubble%0d got %0h want 0", i, valid_b); end
        end
        n_cmp++; if (stall_b !== 1'b0) begin n_fail++; $display("FAIL lat3_release got %0h want 0", stall_b); end
        tick();
        n_cmp++; if (valid_b !== 1'b1 || pc_b !== 10'h101) begin n_fail++; $display("FAIL lat3_dep got %0h/%0h want 1/101", valid_b, pc_b); end
    endtask

    task automatic test_hazard_match();
        do_reset();
        set_id(1, 10'h100, 7'b1000001, 3'd3, 3'd0, 3'd0, 0, 0, 32'h0, 32'h0);
        tick();
        set_id(1, 10'h101, 7'b0000100, 3'd4, 3'd3, 3'd1, 0, 0, 32'h0, 32'h0);
        n_cmp++; if (stall_a !== 1'b0 || stall_b !== 1'b0) begin n_fail++; $display("FAIL no_use_s1 got %0h/%0h want 0/0", stall_a, stall_b); end
        set_id(1, 10'h101, 7'b0000100, 3'd4, 3'd1, 3'd3, 0, 1, 32'h0, 32'h0);
        n_cmp++; if (stall_a !== 1'b1) begin n_fail++; $display("FAIL use_s2_match got %0h want 1", stall_a); end
        do_reset();
        set_id(1, 10'h100, 7'b1000001, 3'd0, 3'd0, 3'd0, 0, 0, 32'h0, 32'h0);
        tick();
        set_id(1, 10'h101, 7'b0000100, 3'd4, 3'd0, 3'd1, 1, 0, 32'h0, 32'h0);
        n_cmp++; if (stall_a !== 1'b1) begin n_fail++; $display("FAIL index0_match got %0h want 1", stall_a); end
        set_id(1, 10'h101, 7'b1000001, 3'd0, 3'd0, 3'd1, 1, 0, 32'h0, 32'h0);
        tick();
        set_id(1, 10'h102, 7'b0000100, 3'd4, 3'd0, 3'd1, 1, 0, 32'h0, 32'h0);
        flush_in = 1;
        tick();
        flush_in = 0; #1;
        n_cmp++; if (stall_b !== 1'b0 || valid_b !== 1'b0) begin n_fail++; $display("FAIL flush_bubble_run got %0h/%0h want 0/0", stall_b, valid_b); end
        tick();
        n_cmp++; if (valid_b !== 1'b1 || pc_b !== 10'h102) begin n_fail++; $display("FAIL flush_then_capture got %0h/%0h want 1/102", valid_b, pc_b); end
    endtask

    task automatic test_stall_flush();
        do_reset();
        set_id(1, 10'h200, 7'b0100000, 3'd2, 3'd0, 3'd0, 0, 0, 32'hDEADBEEF, 32'h5);
        tick();
        stall_in = 1;
        set_id(1, 10'h201, 7'b0000100, 3'd1, 3'd0, 3'd0, 0, 0, 32'h0, 32'h0);
        n_cmp++; if (stall_a !== 1'b1) begin n_fail++; $display("FAIL stall_up_pass got %0h want 1", stall_a); end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++; if (s1_a !== 32'hDEADBEEF || pc_a !== 10'h200 || valid_a !== 1'b1 || ctrl_a !== 7'b0100000) begin
                n_fail++; $display("FAIL stall_hold%0d got s1=%0h pc=%0h v=%0h c=%0h want deadbeef/200/1/20", i, s1_a, pc_a, valid_a, ctrl_a); end
        end
        flush_in = 1;
        tick();
        n_cmp++; if (valid_a !== 1'b0 || ctrl_a[5] !== 1'b0 || s1_a !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL flush_over_stall got v=%0h mw=%0h s1=%0h want 0/0/deadbeef", valid_a, ctrl_a[5], s1_a); end
        flush_in = 0; stall_in = 0;
    endtask

    task automatic test_halt();
        do_reset();
        set_id(1, 10'h0AA, 7'b0000010, 3'd0, 3'd0, 3'd0, 0, 0, 32'h0, 32'h0);
        tick();
        set_id(1, 10'h0AB, 7'b0000101, 3'd1, 3'd0, 3'd0, 0, 0, 32'h0, 32'h0);
        n_cmp++; if (ctrl_a[1] !== 1'b1 || halted_a !== 1'b0 || valid_a !== 1'b1) begin
            n_fail++; $display("FAIL halt_capture got h=%0h hl=%0h v=%0h want 1/0/1", ctrl_a[1], halted_a, valid_a); end
        tick();
        n_cmp++; if (halted_a !== 1'b1 || stall_a !== 1'b1 || valid_a !== 1'b0 || ctrl_a !== 7'h0) begin
            n_fail++; $display("FAIL halt_latched got hl=%0h st=%0h v=%0h c=%0h want 1/1/0/0", halted_a, stall_a, valid_a, ctrl_a); end
        for (int i = 0; i < 3; i++) begin
            flush_in = (i == 1);
            tick();
            n_cmp++; if (halted_a !== 1'b1 || valid_a !== 1'b0) begin n_fail++; $display("FAIL halt_hold%0d got %0h/%0h want 1/0", i, halted_a, valid_a); end
        end
        flush_in = 0;
        rst = 1; #1;
        n_cmp++; if (halted_a !== 1'b0 || stall_a !== 1'b0) begin n_fail++; $display("FAIL halt_rst got %0h/%0h want 0/0", halted_a, stall_a); end
        rst = 0;
        tick();
    endtask

`ifdef ID_EX_FWD_EN
    task automatic test_fwd();
        do_reset();
        wb_regWrite = 1; wb_op0 = 3'd2; wb_data = 32'h12345678;
        set_id(1, 10'h300, 7'b0000101, 3'd4, 3'd5, 3'd2, 1, 1, 32'hAAAA0001, 32'h0);
        tick();
        n_cmp++; if (s2_a !== 32'h12345678 || s1_a !== 32'hAAAA0001) begin
            n_fail++; $display("FAIL fwd got s1=%0h s2=%0h want aaaa0001/12345678", s1_a, s2_a); end
        wb_regWrite = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_capture();
        test_load_use_lat1();
        test_load_use_lat3();
        test_hazard_match();
        test_stall_flush();
        test_halt();
`ifdef ID_EX_FWD_EN
        test_fwd();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/id_ex_pipe_ctrl.md
Name: id_ex_pipe_ctrl

Overview:
Parametrised successor of the ID/EX pipeline register for the RISC microcoprocessor core. It adds a valid bit, downstream stall, flush and a built-in load-use hazard detector that inserts a configurable number of bubbles. It also provides a halt latch that freezes issue once a HALT instruction enters EX. It sits between the decode stage and the ALU/memory execute stage, and drives the upstream stall to the IF/ID register.

Parameters:
pc_width, 10, program counter width
func_width, 6, ALU function field width
const_width, 8, immediate constant width
index_width, 3, register index width
reg_width, 32, register data width
load_lat, 1, bubbles inserted on a load-use hazard; legal range 1..7

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
valid_id  in  1  ID stage holds a real instruction
pc_curr_id / pc_curr_ex  in/out  pc_width  PC of the instruction
func_id / func_ex  in/out  func_width  ALU function
const_id / const_ex  in/out  const_width  immediate
memRead_id, memWrite_id, aluToReg_id, constToReg_id, aluEn_id, halt_id, regWrite_id  in  1 each  decoded controls
memRead_ex, memWrite_ex, aluToReg_ex, constToReg_ex, aluEn_ex, halt_ex, regWrite_ex  out  1 each  registered controls
op0_id / op0_ex  in/out  index_width  destination index
op1_id, op2_id  in  index_width each  source indices of S1/S2
use_s1_id, use_s2_id  in  1 each  instruction reads S1/S2
S1_id / S1_ex, S2_id / S2_ex  in/out  reg_width  operand values
stall_in  in  1  downstream (EX/MEM) cannot accept
flush_in  in  1  squash the instruction entering EX
valid_ex  out  1  EX holds a real instruction
stall_up  out  1  combinational; IF/ID must hold
halted  out  1  halt latched

Behaviour:
- Reset (async, rst=1): all _ex outputs, valid_ex and halted are 0; bubble counter is 0; state is RUN. Release takes effect on the next rising edge.
- States: RUN, BUBBLE, HALTED.
- Bubble load: valid_ex=0 and all seven control outputs=0. Data fields (pc, func, const, op0, S1, S2) hold their previous values.
- Hazard condition (combinational, RUN only): valid_ex & memRead_ex & regWrite_ex & valid_id & ((use_s1_id & op1_id==op0_ex) | (use_s2_id & op2_id==op0_ex)). Index 0 is compared like any other index.
- stall_up = stall_in | hazard | (state==BUBBLE) | (state==HALTED).
- Per-edge priority: rst > flush_in > stall_in > HALTED > hazard/BUBBLE > normal capture.
- flush_in:
  - Loads a bubble, clears the counter and returns BUBBLE to RUN.
  - Does not leave HALTED.
  - Wins over a simultaneous stall_in.
- stall_in (no flush): every EX register, the counter and the state hold.
- HALTED: loads a bubble every cycle and is left only by rst.
- Hazard detected in RUN:
  - Loads a bubble.
  - If load_lat>1, loads counter=load_lat-1 and goes to BUBBLE; if load_lat=1, stays in RUN.
  - With load_lat=1, the hazard clears because memRead_ex is now 0.
- BUBBLE: loads a bubble and decrements the counter each cycle. When it reaches 0 it goes to RUN, so exactly load_lat bubbles are inserted in total.
- Normal capture: all _id fields are copied to _ex and valid_ex=valid_id. Controls are gated with valid_id, so an invalid ID yields zero controls.
- Capturing valid_id=1 with halt_id=1 sets halt_ex=1 that cycle. The state becomes HALTED with halted=1 from the next edge.
- Latency: one cycle from ID to EX.

Optional Feature:
ID_EX_FWD_EN:
- Defined: adds ports wb_regWrite (in 1), wb_op0 (in index_width) and wb_data (in reg_width).
- On normal capture, if wb_regWrite & wb_op0==op1_id then S1_ex<=wb_data; likewise for op2_id and S2_ex. Each operand is bypassed independently.
- Undefined: the ports are absent and S1/S2 are captured unmodified.

Test Plan:
- Reset mid-stream: rst pulse between edges with valid_ex=1 -> all outputs 0 immediately; first capture after release copies pc_curr_id=0x05A.
- Load-use, load_lat=1: EX holds load (memRead, regWrite, op0=3); ID has op1=3, use_s1=1 -> stall_up=1, next valid_ex=0, then the dependent instruction captured one cycle later.
- load_lat=3, same hazard -> stall_up high 3 cycles, 3 bubbles, then capture. use_s1=0 with op1=3 -> no stall.
- stall_in=1 for 2 cycles with S1_ex=0xDEADBEEF -> outputs unchanged. flush_in together with stall_in -> valid_ex=0, memWrite_ex=0.
- HALT: valid halt_id captured -> halt_ex=1, then halted=1, stall_up=1, valid_ex=0 forever. flush_in has no effect; only rst clears it.
- ID_EX_FWD_EN: wb_regWrite=1, wb_op0=2, wb_data=0x12345678, op2_id=2, S2_id=0 -> S2_ex=0x12345678, S1_ex unchanged.
